// File: rtl/tt3_pkg.sv
// Shared types and helpers for the 3-input truth-table sweep checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: sweep FSM state encoding, row count/width, and the lookup that
// maps a row index {in1,in2,in3} to its bit in an 8-bit truth table.
package tt3_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int ROWS  = 8;
    localparam int ROW_W = 3;

    // Row r lives at bit [7-r] so that the table reads MSB-first as row 000..111.
    function automatic logic expected_bit(input logic [7:0] tbl, input logic [ROW_W-1:0] row);
        return tbl[3'(ROWS - 1) - row];
    endfunction

endpackage

// File: rtl/tt3_settle_timer.sv
// Settle-window down counter: holds a row steady for a programmable number of cycles.
// Latency: load takes effect on the next edge; expired is combinational from the count.
// Backpressure: none; counts whenever enabled, parks at zero.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       load load_val into the counter (wins over en)
//   load_val   8-bit reload value
//   en         decrement by one while non-zero
//   expired    count has reached zero
//   count      current counter value
module tt3_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       expired,
    output logic [7:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    assign expired = (count == 8'd0);

endmodule

// File: rtl/tt3_sweep_checker.sv
// Exhaustive sweep of a 3-input combinational gate: drives rows 000..111, samples, compares to TRUTH_TABLE.
// Latency: row r visible E+1+r*(S+1) after start edge E; done pulses in cycle E+8*(S+1)+1.
// Backpressure: none; start is ignored unless idle, abort cancels a sweep in progress.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, abort    begin / cancel a sweep (abort wins when both are seen in IDLE)
//   out_sense       gate output, synchronous to clk
//   in1,in2,in3     row drive to the gate, in1 is the row MSB
//   busy            sweep in progress
//   done            one-cycle completion pulse
//   pass            observed table matched TRUTH_TABLE (valid from done until next start)
//   observed_table  sampled gate outputs, bit [7-r] holds row r
//   mismatch_mask   observed_table ^ TRUTH_TABLE, updated with done
module tt3_sweep_checker #(
    parameter logic [7:0] TRUTH_TABLE   = 8'h97,
    parameter int         SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       out_sense,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] observed_table,
    output logic [7:0] mismatch_mask
);

    import tt3_pkg::*;

    // The counter runs SETTLE_CYCLES-1 down to 0, so DRIVE lasts SETTLE_CYCLES
    // cycles and the extra SAMPLE cycle makes each row S+1 cycles long.
    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t             state;
    logic [ROW_W-1:0]   row;
    logic [ROW_W-1:0]   drive;
    logic [7:0]         mm_acc;

    logic               accept;
    logic               sweeping;
    logic               last_row;
    logic               timer_load;
    logic               timer_en;
    logic               timer_expired;
    logic [7:0]         timer_count;

    assign accept   = (state == IDLE) && start && !abort;
    assign sweeping = (state == DRIVE) || (state == SAMPLE);
    assign last_row = (row == 3'(ROWS - 1));

    // Reload on sweep start and whenever a SAMPLE hands over to the next row.
    assign timer_load = accept || ((state == SAMPLE) && !last_row);
    assign timer_en   = (state == DRIVE);

    tt3_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (RELOAD),
        .en       (timer_en),
        .expired  (timer_expired),
        .count    (timer_count)
    );

    assign {in1, in2, in3} = drive;

    // Outputs are registered copies of the state seen this cycle, so the gate
    // sees a row one cycle after the FSM selects it; the SAMPLE cycle therefore
    // falls after SETTLE_CYCLES cycles of stable drive. Abort overrides the
    // default copies so the gate is released on the very next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            row            <= '0;
            drive          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            observed_table <= 8'd0;
            mismatch_mask  <= 8'd0;
            mm_acc         <= 8'd0;
        end else begin
            done  <= 1'b0;
            busy  <= sweeping;
            drive <= sweeping ? row : '0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state          <= DRIVE;
                        row            <= '0;
                        observed_table <= 8'd0;
                        mismatch_mask  <= 8'd0;
                        mm_acc         <= 8'd0;
                        pass           <= 1'b0;
                    end
                end

                DRIVE: begin
                    if (abort) begin
                        state <= IDLE;
                        row   <= '0;
                        drive <= '0;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else if (timer_expired) begin
                        state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    if (abort) begin
                        state <= IDLE;
                        row   <= '0;
                        drive <= '0;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        observed_table[3'(ROWS - 1) - row] <= out_sense;
                        mm_acc[3'(ROWS - 1) - row]         <= out_sense ^ expected_bit(TRUTH_TABLE, row);
                        if (last_row) begin
                            state <= FINISH;
                        end else begin
                            row   <= row + 3'd1;
                            state <= DRIVE;
                        end
                    end
                end

                FINISH: begin
                    state         <= IDLE;
                    row           <= '0;
                    done          <= 1'b1;
                    mismatch_mask <= mm_acc;
                    pass          <= (mm_acc == 8'd0);
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt3_sweep_checker.sv
// Self-checking bench for tt3_sweep_checker: two instances (S=4 and S=1) each driving a gate model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tt3_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b, abort;
    logic [7:0] gate_tbl;

    logic       a_in1, a_in2, a_in3, a_busy, a_done, a_pass, a_sense;
    logic [7:0] a_obs, a_mm;
    logic       b_in1, b_in2, b_in3, b_busy, b_done, b_pass, b_sense;
    logic [7:0] b_obs, b_mm;

    logic       sel;
    logic [2:0] m_row;
    logic       m_busy, m_done, m_pass;
    logic [7:0] m_obs, m_mm;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate model: row r answers with bit [7-r] of the table being emulated.
    function automatic logic gate_out(input logic [7:0] t, input logic [2:0] r);
        logic [7:0] sh;
        sh = t >> (7 - int'(r));
        return sh[0];
    endfunction

    assign a_sense = gate_out(gate_tbl, {a_in1, a_in2, a_in3});
    assign b_sense = gate_out(gate_tbl, {b_in1, b_in2, b_in3});

    assign m_row  = sel ? {b_in1, b_in2, b_in3} : {a_in1, a_in2, a_in3};
    assign m_busy = sel ? b_busy : a_busy;
    assign m_done = sel ? b_done : a_done;
    assign m_pass = sel ? b_pass : a_pass;
    assign m_obs  = sel ? b_obs  : a_obs;
    assign m_mm   = sel ? b_mm   : a_mm;

    tt3_sweep_checker #(.TRUTH_TABLE(8'h97), .SETTLE_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .out_sense(a_sense),
        .in1(a_in1), .in2(a_in2), .in3(a_in3), .busy(a_busy), .done(a_done),
        .pass(a_pass), .observed_table(a_obs), .mismatch_mask(a_mm)
    );

    tt3_sweep_checker #(.TRUTH_TABLE(8'h97), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .out_sense(b_sense),
        .in1(b_in1), .in2(b_in2), .in3(b_in3), .busy(b_busy), .done(b_done),
        .pass(b_pass), .observed_table(b_obs), .mismatch_mask(b_mm)
    );

    // intr_mode: 0 none, 1 abort during intr_row, 2 reset during intr_row.
    task automatic run_sweep(input string name, input bit use_b, input logic [7:0] gt,
                             input int intr_mode, input int intr_row, input bit repulse);
        int s, e, last, k, row, intr_at;
        bit stopped;
        logic [7:0] part_mask;
        s         = use_b ? 1 : 4;
        sel       = use_b;
        gate_tbl  = gt;
        intr_at   = -1;
        stopped   = 1'b0;
        part_mask = ~(8'hFF >> intr_row);
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        e    = cyc;
        last = e + 8 * (s + 1) + 1;
        for (int c = e + 1; c <= last + 2; c++) begin
            @(negedge clk);
            k = c - e - 1;
            if (c == intr_at) begin
                abort = 1'b0;
                rst   = 1'b0;
                stopped = 1'b1;
                n_tests++;
                if (m_row !== 3'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_pass !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s intr_outputs: got row=%0d busy=%b done=%b pass=%b want 0/0/0/0",
                             name, m_row, m_busy, m_done, m_pass);
                end
                n_tests++;
                if (m_obs !== ((intr_mode == 1) ? (gt & part_mask) : 8'h00)) begin
                    n_fail++;
                    $display("FAIL %s intr_observed: got %h want %h", name, m_obs,
                             (intr_mode == 1) ? (gt & part_mask) : 8'h00);
                end
            end else if (stopped) begin
                n_tests++;
                if (m_done !== 1'b0 || m_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s no_done_after_intr: got done=%b busy=%b want 0/0", name, m_done, m_busy);
                end
            end else if (c < last) begin
                row = k / (s + 1);
                n_tests++;
                if (m_row !== 3'(row) || m_busy !== 1'b1 || m_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s row_drive k=%0d: got row=%0d busy=%b done=%b want row=%0d busy=1 done=0",
                             name, k, m_row, m_busy, m_done, row);
                end
                if (intr_mode == 1 && row == intr_row && (k % (s + 1)) == 0) begin
                    abort   = 1'b1;
                    intr_at = c + 1;
                end
                if (intr_mode == 2 && row == intr_row && (k % (s + 1)) == s) begin
                    #2 rst = 1'b1;
                    #1;
                    n_tests++;
                    if (m_row !== 3'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_pass !== 1'b0 ||
                        m_obs !== 8'h00 || m_mm !== 8'h00) begin
                        n_fail++;
                        $display("FAIL %s async_reset: got row=%0d busy=%b done=%b pass=%b obs=%h mm=%h want all 0",
                                 name, m_row, m_busy, m_done, m_pass, m_obs, m_mm);
                    end
                    intr_at = c + 1;
                end
                if (repulse && k == 7)        begin if (use_b) start_b = 1'b1; else start_a = 1'b1; end
                if (repulse && k == 8)        begin start_a = 1'b0; start_b = 1'b0; end
                if (repulse && c == last - 1) begin if (use_b) start_b = 1'b1; else start_a = 1'b1; end
            end else if (c == last) begin
                start_a = 1'b0;
                start_b = 1'b0;
                n_tests++;
                if (m_done !== 1'b1 || m_busy !== 1'b0 || m_row !== 3'd0) begin
                    n_fail++;
                    $display("FAIL %s done_timing: got done=%b busy=%b row=%0d want 1/0/0", name, m_done, m_busy, m_row);
                end
                n_tests++;
                if (m_obs !== gt || m_mm !== (gt ^ 8'h97) || m_pass !== (gt == 8'h97)) begin
                    n_fail++;
                    $display("FAIL %s result: got obs=%h mm=%h pass=%b want obs=%h mm=%h pass=%b",
                             name, m_obs, m_mm, m_pass, gt, gt ^ 8'h97, gt == 8'h97);
                end
            end else begin
                n_tests++;
                if (m_done !== 1'b0 || m_busy !== 1'b0 || m_obs !== gt || m_pass !== (gt == 8'h97)) begin
                    n_fail++;
                    $display("FAIL %s hold_after_done: got done=%b busy=%b obs=%h pass=%b want 0/0/%h/%b",
                             name, m_done, m_busy, m_obs, m_pass, gt, gt == 8'h97);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; gate_tbl = 8'h97; sel = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({a_in1, a_in2, a_in3, a_busy, a_done, a_pass} !== 6'b0 || a_obs !== 8'h00 || a_mm !== 8'h00 ||
            {b_in1, b_in2, b_in3, b_busy, b_done, b_pass} !== 6'b0 || b_obs !== 8'h00 || b_mm !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: got a=%b%b%b%b%b%b/%h/%h b=%b%b%b%b%b%b/%h/%h want all 0",
                     a_in1, a_in2, a_in3, a_busy, a_done, a_pass, a_obs, a_mm,
                     b_in1, b_in2, b_in3, b_busy, b_done, b_pass, b_obs, b_mm);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_golden();
        run_sweep("golden", 1'b0, 8'h97, 0, 0, 1'b0);
    endtask

    task automatic test_stuck0();
        run_sweep("stuck0", 1'b0, 8'h00, 0, 0, 1'b0);
    endtask

    task automatic test_row5_inverted();
        run_sweep("row5_inv", 1'b1, 8'h97 ^ 8'h04, 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        run_sweep("abort_row3", 1'b0, 8'h97, 1, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_sweep("repulse", 1'b0, 8'h97, 0, 0, 1'b1);
        @(negedge clk);
        start_a = 1'b1;
        abort   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            abort   = 1'b0;
            n_tests++;
            if (a_busy !== 1'b0 || {a_in1, a_in2, a_in3} !== 3'd0 || a_done !== 1'b0) begin
                n_fail++;
                $display("FAIL start_abort_idle cyc%0d: got busy=%b row=%0d done=%b want 0/0/0",
                         i, a_busy, {a_in1, a_in2, a_in3}, a_done);
            end
        end
    endtask

    task automatic test_rst_mid();
        run_sweep("rst_row6", 1'b0, 8'h97, 2, 6, 1'b0);
        run_sweep("after_rst", 1'b0, 8'h97, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] gt;
        int mode, irow;
        bit ub;
        for (int i = 0; i < 8; i++) begin
            gt   = ($urandom_range(0, 3) == 0) ? 8'h97 : 8'($urandom);
            ub   = 1'($urandom_range(0, 1));
            mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            irow = int'($urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_sweep($sformatf("rand%0d", i), ub, gt, mode, irow, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_stuck0();
        test_row5_inverted();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
